rf_wb_arbiter: RTL and testbench

//  Shares the single synchronous register-file write port between two writeback sources:

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_grant.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 74 +++++++
 tb/tb_rf_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file write-port types for the writeback arbiter.
// Pure declarations: no latency, no backpressure.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] RF_X0 = 5'd0;

    typedef struct packed {
        logic                 wen;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    // x0 is hardwired to zero, so writes aimed at it are discarded.
    function automatic logic is_x0(input logic [RF_ADDR_W-1:0] addr);
        return addr == RF_X0;
    endfunction

endpackage

// File: rtl/rf_wb_grant.sv
// Grant logic for the two writeback requesters; RF_WB_ARB_RR_EN selects round robin.
// Readies are combinational from valids and local state, and are low while reset is asserted.
module rf_wb_grant #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wb0_valid,
    input  logic wb1_valid,
    output logic wb0_ready,
    output logic wb1_ready
);

`ifdef RF_WB_ARB_RR_EN

    // rr_ptr remembers the last winner; the other side wins a tie.
    logic rr_ptr;
    logic both_valid;

    always_comb begin
        both_valid = wb0_valid && wb1_valid;
        wb0_ready  = rst_n && !(both_valid && !rr_ptr);
        wb1_ready  = rst_n && wb1_valid && (!wb0_valid || !rr_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (wb0_valid && wb0_ready) begin
            rr_ptr <= 1'b0;
        end else if (wb1_valid && wb1_ready) begin
            rr_ptr <= 1'b1;
        end
    end

`else

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             force_grant;

    // After MAX_WAIT stalled cycles requester 1 overrides the fixed priority once.
    always_comb begin
        force_grant = (wait_cnt == CNT_MAX) && wb1_valid;
        wb0_ready   = rst_n && !force_grant;
        wb1_ready   = rst_n && wb1_valid && (!wb0_valid || force_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (wb1_valid && !wb1_ready) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter; RF_WB_ARB_RR_EN swaps priority+guard for round robin.
// Winning write is staged one cycle before the rf port; the rf port never back-pressures.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb0_valid,
    output logic              o_wb0_ready,
    input  logic [ADDR_W-1:0] i_wb0_addr,
    input  logic [DATA_W-1:0] i_wb0_data,
    input  logic              i_wb1_valid,
    output logic              o_wb1_ready,
    input  logic [ADDR_W-1:0] i_wb1_addr,
    input  logic [DATA_W-1:0] i_wb1_data,
    output logic              o_rd_wen,
    output logic [ADDR_W-1:0] o_rd_waddr,
    output logic [DATA_W-1:0] o_rd_wdata
);

    logic   wb0_ready;
    logic   wb1_ready;
    logic   xfer0;
    logic   xfer1;
    rf_wr_t wr_d;
    rf_wr_t wr_q;

    rf_wb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .wb0_valid (i_wb0_valid),
        .wb1_valid (i_wb1_valid),
        .wb0_ready (wb0_ready),
        .wb1_ready (wb1_ready)
    );

    assign o_wb0_ready = wb0_ready;
    assign o_wb1_ready = wb1_ready;
    assign xfer0       = i_wb0_valid && wb0_ready;
    assign xfer1       = i_wb1_valid && wb1_ready;

    // Address/data hold their last value on idle cycles; only wen pulses.
    always_comb begin
        wr_d      = wr_q;
        wr_d.wen  = 1'b0;
        if (xfer0) begin
            wr_d.addr = i_wb0_addr;
            wr_d.data = i_wb0_data;
        end else if (xfer1) begin
            wr_d.addr = i_wb1_addr;
            wr_d.data = i_wb1_data;
        end
        wr_d.wen = (xfer0 || xfer1) && !is_x0(wr_d.addr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
        end else begin
            wr_q <= wr_d;
        end
    end

    assign o_rd_wen   = wr_q.wen;
    assign o_rd_waddr = wr_q.addr;
    assign o_rd_wdata = wr_q.data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by random traffic.
module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        wb0_valid, wb1_valid;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        rd_wen;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb0_valid (wb0_valid),
        .o_wb0_ready (wb0_ready),
        .i_wb0_addr  (wb0_addr),
        .i_wb0_data  (wb0_data),
        .i_wb1_valid (wb1_valid),
        .o_wb1_ready (wb1_ready),
        .i_wb1_addr  (wb1_addr),
        .i_wb1_data  (wb1_data),
        .o_rd_wen    (rd_wen),
        .o_rd_waddr  (rd_waddr),
        .o_rd_wdata  (rd_wdata)
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [31:0] rf_act[32];

    // Requester-side pending transactions (held stable until accepted)
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    // Reference model state
    int          stall1;
    logic        last_win;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rf write must match the oldest expected write, in the right cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_write: no write seen, expected x%0d=%h in cycle %0d", e.addr, e.data, e.cyc);
                end
                if (rd_wen) begin
                    rf_act[rd_waddr] = rd_wdata;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_write: got x%0d=%h required no write", rd_waddr, rd_wdata);
                    end else begin
                        e = sbq.pop_front();
                        chk("write_cycle", cyc, e.cyc);
                        chk("write_addr", {27'd0, rd_waddr}, {27'd0, e.addr});
                        chk("write_data", rd_wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        if (addr != 5'd0) begin
            e.cyc  = cyc + 1;
            e.addr = addr;
            e.data = data;
            sbq.push_back(e);
        end
    endtask

    // One cycle: drive pending requests, check readies against the model, record transfers.
    task automatic step(output logic t0, output logic t1);
        logic e0, e1;
        @(negedge clk);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        #1;
`ifdef RF_WB_ARB_RR_EN
        if (v0 && v1) begin
            e0 = last_win;
            e1 = !last_win;
        end else begin
            e0 = 1'b1;
            e1 = v1;
        end
`else
        if (v1 && stall1 >= MAX_WAIT) begin
            e0 = 1'b0;
            e1 = 1'b1;
        end else begin
            e0 = 1'b1;
            e1 = v1 && !v0;
        end
`endif
        chk("wb0_ready", {31'd0, wb0_ready}, {31'd0, e0});
        chk("wb1_ready", {31'd0, wb1_ready}, {31'd0, e1});
        t0 = v0 && e0;
        t1 = v1 && e1;
        if (t0) push_exp(a0, d0);
        else if (t1) push_exp(a1, d1);
        if (v1 && !t1) stall1 = (stall1 < MAX_WAIT) ? stall1 + 1 : stall1;
        else stall1 = 0;
        if (t0) last_win = 1'b0;
        else if (t1) last_win = 1'b1;
        if (t0) v0 = 1'b0;
        if (t1) v1 = 1'b1 ? 1'b0 : 1'b0;
    endtask

    task automatic idle(input int n);
        logic t0, t1;
        for (int i = 0; i < n; i++) step(t0, t1);
    endtask

    task automatic model_reset();
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        stall1 = 0;
        last_win = 1'b0;
    endtask

    initial begin
        logic t0, t1;
        int   n;
        int   nx;
        for (int i = 0; i < 32; i++) rf_act[i] = 32'd0;
        model_reset();
        wb0_valid = 0; wb1_valid = 0;
        wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_wen", {31'd0, rd_wen}, 32'd0);
        chk("reset_waddr", {27'd0, rd_waddr}, 32'd0);
        chk("reset_wdata", rd_wdata, 32'd0);
        wb0_valid = 1'b1; wb1_valid = 1'b1;
        #1;
        chk("reset_ready0", {31'd0, wb0_ready}, 32'd0);
        chk("reset_ready1", {31'd0, wb1_ready}, 32'd0);
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

`ifdef RF_WB_ARB_RR_EN
        // Both requesters continuously valid: six back-to-back grants, alternating.
        nx = 0;
        for (int i = 0; i < 6; i++) begin
            if (!v0) begin v0 = 1; a0 = 5'd10; d0 = 32'h100 + i; end
            if (!v1) begin v1 = 1; a1 = 5'd11; d1 = 32'h200 + i; end
            step(t0, t1);
            if (t0 || t1) nx++;
            chk("rr_winner", {31'd0, t1}, {31'd0, ~i[0]});
        end
        chk("rr_grants", nx, 6);
        v0 = 0; v1 = 0;
        idle(2);
`endif

        // Single request from requester 0.
        v0 = 1; a0 = 5'd3; d0 = 32'hDEAD_BEEF;
        step(t0, t1);
        chk("single_xfer0", {31'd0, t0}, 32'd1);
        idle(2);
        chk("single_rf_x3", rf_act[3], 32'hDEAD_BEEF);

`ifndef RF_WB_ARB_RR_EN
        // Same destination from both requesters: req 0 first, req 1 wins the register.
        v0 = 1; a0 = 5'd7; d0 = 32'h11;
        v1 = 1; a1 = 5'd7; d1 = 32'h22;
        step(t0, t1);
        chk("conflict_first_is_wb0", {30'd0, t0, t1}, 32'd2);
        step(t0, t1);
        chk("conflict_second_is_wb1", {30'd0, t0, t1}, 32'd1);
        idle(2);
        chk("conflict_rf_x7", rf_act[7], 32'h22);

        // Starvation guard: two rounds show the counter re-arming after the forced grant.
        for (int r = 0; r < 2; r++) begin
            v1 = 1; a1 = 5'd9; d1 = 32'h900 + r;
            n = 0;
            t1 = 0;
            while (!t1 && n < 12) begin
                if (!v0) begin v0 = 1; a0 = 5'(12 + n); d0 = $urandom; end
                step(t0, t1);
                n++;
            end
            chk("starve_cycles_to_grant", n, MAX_WAIT + 1);
            chk("starve_wb0_blocked", {31'd0, t0}, 32'd0);
        end
        v0 = 0;
        idle(2);
`endif

        // Write to x0 is accepted but never reaches the register file.
        v1 = 1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
        step(t0, t1);
        chk("x0_accepted", {31'd0, t1}, 32'd1);
        idle(2);
        chk("x0_reads_zero", rf_act[0], 32'd0);

        // Asynchronous reset while a write to x5 is staged.
        v0 = 1; a0 = 5'd5; d0 = 32'h5555_AAAA;
        step(t0, t1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_wen", {31'd0, rd_wen}, 32'd0);
        chk("midreset_waddr", {27'd0, rd_waddr}, 32'd0);
        chk("midreset_wdata", rd_wdata, 32'd0);
        sbq.delete();
        model_reset();
        wb0_valid = 0; wb1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("midreset_rf_x5", rf_act[5], 32'd0);

        // Random traffic with phases of heavy requester-0 load.
        for (int i = 0; i < 2000; i++) begin
            int p0;
            p0 = ((i / 200) % 2 == 1) ? 95 : 50;
            if (!v0 && $urandom_range(99) < p0) begin
                v0 = 1; a0 = 5'($urandom_range(31)); d0 = $urandom;
            end
            if (!v1 && $urandom_range(99) < 40) begin
                v1 = 1; a1 = 5'($urandom_range(31)); d1 = $urandom;
            end
            step(t0, t1);
        end
        v0 = 0; v1 = 0;
        idle(3);
        chk("final_queue_empty", sbq.size(), 0);
        chk("final_rf_x0", rf_act[0], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
